pcs_tx_pack: RTL and testbench
==============================

# pcs_tx_pack

Transmit-side frame packer for the PCS link. It builds fixed 528-word frames of 64-bit PCS data: a sync header, two control words, auxiliary UART/audio payload words and 480 video words. It sits between the local video line FIFO / auxiliary sources and the PCS transmit FIFO. The frame format is bit-compatible with the existing receive unpacker.

## Interface
- P_FRAME_LEN, 528, total words per frame
- P_VALID_LEN, 512, words per frame written to the PCS FIFO
- P_VIDEO_S, 9, word index of the first video word
- P_VIDEO_LEN, 480, video words per frame
- i_pcs_clk  in  1  PCS clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_tx_en  in  1  level; enables framing
- i_video_lock  in  1  source video locked flag
- i_video_vsyn  in  1  frame-level vertical sync of the source
- i_line_ready  in  1  line FIFO holds ≥480 words
- o_video_rd_en  out  1  line FIFO read strobe (1-cycle read latency)
- i_video_data  in  64  line FIFO read data
- i_para  in  9×13 (117)  packed timing parameters; slot k = bits [13k+12:13k]; slot 0 = resolution (low 8 bits used)
- i_uart_req, i_audio0_req, i_audio1_req  in  1 each  level request, held until ack
- i_uart_data  in  32; i_audio0_data, i_audio1_data  in  64 each
- o_uart_ack, o_audio0_ack, o_audio1_ack  out  1 each  one-cycle ack pulse
- o_pcs_head  out  1  header flag
- o_pcs_data  out  64  frame word
- o_pcs_valid  out  1  write strobe to PCS FIFO
- o_frame_start  out  1  pulse on word 0

## Operation
- Word counter r_cnt 0..P_FRAME_LEN-1. States are IDLE and RUN.
- IDLE: r_cnt held at 0. Move to RUN when i_tx_en=1.
- RUN: r_cnt increments every cycle and wraps to 0 after 527. When i_tx_en=0 at the wrap, go to IDLE. Deassertion mid-frame always completes the current frame.
- Frame word contents, indexed by r_cnt:
  - 0: data 0, head 0.
  - 1: head=1, data=64'h00000000000000FB.
  - 2: [7:0]=resolution (slot 0 low 8 bits); [8]=i_video_lock; [18:9]=one-hot bitmap 1<<k; all other bits 0.
  - 3: [0]=uart_en, [1]=audio0_en, [2]=audio1_en, [3]=video_ready, [4]=vsyn, [17:5]=para slot k, [63:18]=0.
  - 4: uart payload in [31:0]. 5: audio0 payload. 6: audio1 payload. Each is 0 when its en flag is 0.
  - 7..8: 0.
  - 9..488: video words when video_ready=1, otherwise 0.
  - 489..527: 0.
- Parameter slot k rotates 0..8, one slot per frame. k advances at r_cnt=527 and wraps 8→0. Reset value of k is 0. Slot data is sampled at r_cnt=2 and held for the frame.
- Flags are latched at r_cnt=2: video_ready=i_line_ready, vsyn=i_video_vsyn, xx_en=i_xx_req. A payload is captured on the same cycle when its request is high.
- Each ack pulses at r_cnt=2 for every request that was latched. The source drops or updates its request on the next cycle.
- o_video_rd_en=1 for r_cnt 8..487 only when video_ready=1 for this frame. i_video_data returned at r_cnt 9..488 is placed into words 9..488.
- o_pcs_valid=1 for r_cnt < P_VALID_LEN while in RUN. Words 512..527 are generated internally but not written.

## Timing
- All outputs are registered except o_video_rd_en, which is decoded combinationally from r_cnt and the latched video_ready.
- The word for index n appears on o_pcs_data/o_pcs_head/o_pcs_valid one cycle after r_cnt=n.
- o_frame_start and the acks follow the same one-cycle offset: they are asserted the cycle after r_cnt=0 and r_cnt=2 respectively.
- IDLE→RUN: r_cnt=0 on the first RUN cycle. Word 0 is output on the next cycle.
- Reset values: r_cnt=0, state IDLE, k=0, all latched flags and payloads 0, o_pcs_data=0, o_pcs_head=0, o_pcs_valid=0, o_frame_start=0, all acks 0, o_video_rd_en=0.
- Reset mid-frame aborts immediately with no partial-frame completion. The next frame starts from word 0 and slot 0.
- i_line_ready falling mid-frame does not stop reads; the bit latched at r_cnt=2 governs the whole frame.
- A request that rises after r_cnt=2 waits for the next frame.

## Test plan
- Reset, then i_tx_en=1 for one full frame with no requests and i_line_ready=0. Required: 512 valid words; word 1 has head=1 and data 0xFB; all words except 1–3 are 0; o_video_rd_en never high.
- i_line_ready=1 with FIFO data = incrementing 0..479. Required: o_video_rd_en high for exactly 480 cycles; words 9..488 equal 0..479; word 3 bit3=1.
- i_uart_req=1, data 0xDEADBEEF, held until ack. Required: one ack pulse; word 4 = 0x00000000DEADBEEF; word 3 bit0=1; the next frame has bit0=0.
- Set i_para slot 2=1125. Run 10 frames. Required: frame 2 word 2 [18:9]=0x004 and word 3 [17:5]=1125; frame 9 uses slot 0 again.
- Deassert i_tx_en at word 100. Required: the frame completes through word 527, then the block enters IDLE with o_pcs_valid=0.
- Assert i_rst_n=0 at word 300, then release it. Required: all outputs return to 0 immediately; the next frame starts at word 0 with bitmap 0x001.

Source files
------------

// File: rtl/pcs_tx_pack.sv
// pcs_tx_pack -- transmit-side PCS frame packer.
//
// Builds fixed P_FRAME_LEN-word frames of 64-bit words: a sync header word,
// two control words, three auxiliary payload words (UART, audio0, audio1)
// and P_VIDEO_LEN video words read from the line FIFO. Only the first
// P_VALID_LEN words of each frame are written to the PCS transmit FIFO.
//
// Ports:
//   i_pcs_clk, i_rst_n          clock, asynchronous active-low reset
//   i_tx_en                     level enable; a frame in progress always completes
//   i_video_lock/_vsyn          source status, sampled at word 2
//   i_line_ready                line FIFO holds a full line, sampled at word 2
//   o_video_rd_en/i_video_data  line FIFO read strobe / data (1-cycle latency)
//   i_para                      9 packed 13-bit timing slots, one sent per frame
//   i_*_req/i_*_data/o_*_ack    aux sources: level request, payload, 1-cycle ack
//   o_pcs_head/_data/_valid     frame word and its write strobe
//   o_frame_start               pulse with word 0
//   o_dbg_state                 FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: an aux source holds i_*_req and i_*_data stable until it sees
// o_*_ack; the request level present at word 2 is the one honoured for the
// frame, and the ack pulses in the cycle word 2 leaves the block. Word n is
// presented on the outputs the cycle after the word counter equals n.
module pcs_tx_pack #(
  parameter int P_FRAME_LEN = 528,
  parameter int P_VALID_LEN = 512,
  parameter int P_VIDEO_S   = 9,
  parameter int P_VIDEO_LEN = 480
) (
  input  logic          i_pcs_clk,
  input  logic          i_rst_n,
  input  logic          i_tx_en,
  input  logic          i_video_lock,
  input  logic          i_video_vsyn,
  input  logic          i_line_ready,
  output logic          o_video_rd_en,
  input  logic [63:0]   i_video_data,
  input  logic [116:0]  i_para,
  input  logic          i_uart_req,
  input  logic          i_audio0_req,
  input  logic          i_audio1_req,
  input  logic [31:0]   i_uart_data,
  input  logic [63:0]   i_audio0_data,
  input  logic [63:0]   i_audio1_data,
  output logic          o_uart_ack,
  output logic          o_audio0_ack,
  output logic          o_audio1_ack,
  output logic          o_pcs_head,
  output logic [63:0]   o_pcs_data,
  output logic          o_pcs_valid,
  output logic          o_frame_start,
  output logic          o_dbg_state
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [9:0] CNT_LAST   = 10'(P_FRAME_LEN - 1);
  localparam logic [9:0] CNT_VALID  = 10'(P_VALID_LEN);
  localparam logic [9:0] VID_S      = 10'(P_VIDEO_S);
  localparam logic [9:0] VID_E      = 10'(P_VIDEO_S + P_VIDEO_LEN);
  localparam logic [9:0] RD_S       = 10'(P_VIDEO_S - 1);
  localparam logic [9:0] RD_E       = 10'(P_VIDEO_S - 1 + P_VIDEO_LEN);
  localparam logic [3:0] SLOT_LAST  = 4'd8;

  state_t       state_q, state_d;
  logic [9:0]   cnt_q, cnt_d;
  logic [3:0]   slot_k_q, slot_k_d;
  logic         video_ready_q, video_ready_d;
  logic         vsyn_q, vsyn_d;
  logic         uart_en_q, uart_en_d;
  logic         audio0_en_q, audio0_en_d;
  logic         audio1_en_q, audio1_en_d;
  logic [31:0]  uart_data_q, uart_data_d;
  logic [63:0]  audio0_data_q, audio0_data_d;
  logic [63:0]  audio1_data_q, audio1_data_d;
  logic [12:0]  para_lat_q, para_lat_d;
  logic [63:0]  pcs_data_q, pcs_data_d;
  logic         pcs_head_q, pcs_head_d;
  logic         pcs_valid_q, pcs_valid_d;
  logic         frame_start_q, frame_start_d;
  logic         uart_ack_q, uart_ack_d;
  logic         audio0_ack_q, audio0_ack_d;
  logic         audio1_ack_q, audio1_ack_d;

  logic         run;
  logic         at_latch;
  logic [12:0]  para_sel;
  logic [9:0]   bitmap;

  // Parameter slot currently selected by the rotating index.
  always_comb begin
    para_sel = 13'd0;
    for (int i = 0; i < 9; i++) begin
      if (slot_k_q == 4'(i)) para_sel = i_para[13*i +: 13];
    end
  end

  assign run      = (state_q == ST_RUN);
  assign at_latch = run && (cnt_q == 10'd2);
  assign bitmap   = 10'd1 << slot_k_q;

  // Next-state, per-frame latches and the registered word.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    slot_k_d      = slot_k_q;
    video_ready_d = video_ready_q;
    vsyn_d        = vsyn_q;
    uart_en_d     = uart_en_q;
    audio0_en_d   = audio0_en_q;
    audio1_en_d   = audio1_en_q;
    uart_data_d   = uart_data_q;
    audio0_data_d = audio0_data_q;
    audio1_data_d = audio1_data_q;
    para_lat_d    = para_lat_q;
    pcs_data_d    = 64'd0;
    pcs_head_d    = 1'b0;
    pcs_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    uart_ack_d    = 1'b0;
    audio0_ack_d  = 1'b0;
    audio1_ack_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 10'd0;
        if (i_tx_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          // The enable is only looked at on the wrap, so a frame never truncates.
          cnt_d    = 10'd0;
          slot_k_d = (slot_k_q == SLOT_LAST) ? 4'd0 : slot_k_q + 4'd1;
          if (!i_tx_en) state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 10'd0;
      end
    endcase

    if (at_latch) begin
      video_ready_d = i_line_ready;
      vsyn_d        = i_video_vsyn;
      uart_en_d     = i_uart_req;
      audio0_en_d   = i_audio0_req;
      audio1_en_d   = i_audio1_req;
      para_lat_d    = para_sel;
      if (i_uart_req)   uart_data_d   = i_uart_data;
      if (i_audio0_req) audio0_data_d = i_audio0_data;
      if (i_audio1_req) audio1_data_d = i_audio1_data;
      uart_ack_d    = i_uart_req;
      audio0_ack_d  = i_audio0_req;
      audio1_ack_d  = i_audio1_req;
    end

    if (run) begin
      pcs_valid_d   = (cnt_q < CNT_VALID);
      frame_start_d = (cnt_q == 10'd0);
      case (cnt_q)
        10'd1: begin
          pcs_head_d = 1'b1;
          pcs_data_d = 64'h0000_0000_0000_00FB;
        end
        10'd2: begin
          pcs_data_d[7:0]  = i_para[7:0];
          pcs_data_d[8]    = i_video_lock;
          pcs_data_d[18:9] = bitmap;
        end
        // Word 3 reads the flags latched on the previous cycle.
        10'd3: begin
          pcs_data_d[0]    = uart_en_q;
          pcs_data_d[1]    = audio0_en_q;
          pcs_data_d[2]    = audio1_en_q;
          pcs_data_d[3]    = video_ready_q;
          pcs_data_d[4]    = vsyn_q;
          pcs_data_d[17:5] = para_lat_q;
        end
        10'd4: if (uart_en_q)   pcs_data_d = {32'd0, uart_data_q};
        10'd5: if (audio0_en_q) pcs_data_d = audio0_data_q;
        10'd6: if (audio1_en_q) pcs_data_d = audio1_data_q;
        default: begin
          if (video_ready_q && (cnt_q >= VID_S) && (cnt_q < VID_E))
            pcs_data_d = i_video_data;
        end
      endcase
    end
  end

  // Read strobe leads the video words by one cycle to cover the FIFO latency.
  assign o_video_rd_en = run && video_ready_q && (cnt_q >= RD_S) && (cnt_q < RD_E);

  always_ff @(posedge i_pcs_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 10'd0;
      slot_k_q      <= 4'd0;
      video_ready_q <= 1'b0;
      vsyn_q        <= 1'b0;
      uart_en_q     <= 1'b0;
      audio0_en_q   <= 1'b0;
      audio1_en_q   <= 1'b0;
      uart_data_q   <= 32'd0;
      audio0_data_q <= 64'd0;
      audio1_data_q <= 64'd0;
      para_lat_q    <= 13'd0;
      pcs_data_q    <= 64'd0;
      pcs_head_q    <= 1'b0;
      pcs_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      uart_ack_q    <= 1'b0;
      audio0_ack_q  <= 1'b0;
      audio1_ack_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      slot_k_q      <= slot_k_d;
      video_ready_q <= video_ready_d;
      vsyn_q        <= vsyn_d;
      uart_en_q     <= uart_en_d;
      audio0_en_q   <= audio0_en_d;
      audio1_en_q   <= audio1_en_d;
      uart_data_q   <= uart_data_d;
      audio0_data_q <= audio0_data_d;
      audio1_data_q <= audio1_data_d;
      para_lat_q    <= para_lat_d;
      pcs_data_q    <= pcs_data_d;
      pcs_head_q    <= pcs_head_d;
      pcs_valid_q   <= pcs_valid_d;
      frame_start_q <= frame_start_d;
      uart_ack_q    <= uart_ack_d;
      audio0_ack_q  <= audio0_ack_d;
      audio1_ack_q  <= audio1_ack_d;
    end
  end

  assign o_pcs_data    = pcs_data_q;
  assign o_pcs_head    = pcs_head_q;
  assign o_pcs_valid   = pcs_valid_q;
  assign o_frame_start = frame_start_q;
  assign o_uart_ack    = uart_ack_q;
  assign o_audio0_ack  = audio0_ack_q;
  assign o_audio1_ack  = audio1_ack_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_pcs_tx_pack.sv
module tb_pcs_tx_pack;

  // ---------------- clock / reset / DUT ----------------
  logic          i_pcs_clk = 1'b0;
  logic          i_rst_n;
  logic          i_tx_en;
  logic          i_video_lock;
  logic          i_video_vsyn;
  logic          i_line_ready;
  logic          o_video_rd_en;
  logic [63:0]   i_video_data;
  logic [116:0]  i_para;
  logic          i_uart_req, i_audio0_req, i_audio1_req;
  logic [31:0]   i_uart_data;
  logic [63:0]   i_audio0_data, i_audio1_data;
  logic          o_uart_ack, o_audio0_ack, o_audio1_ack;
  logic          o_pcs_head;
  logic [63:0]   o_pcs_data;
  logic          o_pcs_valid;
  logic          o_frame_start;
  logic          o_dbg_state;

  always #5 i_pcs_clk = ~i_pcs_clk;

  pcs_tx_pack dut (
    .i_pcs_clk     (i_pcs_clk),
    .i_rst_n       (i_rst_n),
    .i_tx_en       (i_tx_en),
    .i_video_lock  (i_video_lock),
    .i_video_vsyn  (i_video_vsyn),
    .i_line_ready  (i_line_ready),
    .o_video_rd_en (o_video_rd_en),
    .i_video_data  (i_video_data),
    .i_para        (i_para),
    .i_uart_req    (i_uart_req),
    .i_audio0_req  (i_audio0_req),
    .i_audio1_req  (i_audio1_req),
    .i_uart_data   (i_uart_data),
    .i_audio0_data (i_audio0_data),
    .i_audio1_data (i_audio1_data),
    .o_uart_ack    (o_uart_ack),
    .o_audio0_ack  (o_audio0_ack),
    .o_audio1_ack  (o_audio1_ack),
    .o_pcs_head    (o_pcs_head),
    .o_pcs_data    (o_pcs_data),
    .o_pcs_valid   (o_pcs_valid),
    .o_frame_start (o_frame_start),
    .o_dbg_state   (o_dbg_state)
  );

  // ---------------- shared state ----------------
  typedef struct {
    logic        lock;
    logic        vsyn;
    logic        line_ready;
    logic        ureq;
    logic        a0req;
    logic        a1req;
    logic        late_ureq;
    logic [31:0] ud;
    logic [31:0] late_ud;
    logic [63:0] a0d;
    logic [63:0] a1d;
    int          drop_en_at;
    int          rst_at;
  } frame_cfg_t;

  // Entry: {word index[9:0], acks[2:0], frame_start, head, data[63:0]}
  logic [78:0]  exp_q[$];
  logic [12:0]  para_slot[9];
  logic [63:0]  rd_total = 64'd0;
  int           exp_k = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference word for index n of a frame sent with configuration c and slot k.
  function automatic logic [68:0] exp_word(input int n, input frame_cfg_t c,
                                           input int k, input logic [63:0] base);
    logic [2:0]  acks;
    logic        fs;
    logic        head;
    logic [63:0] d;
    acks = 3'b000;
    fs   = 1'b0;
    head = 1'b0;
    d    = 64'd0;
    if (n == 0) fs = 1'b1;
    else if (n == 1) begin
      head = 1'b1;
      d    = 64'hFB;
    end else if (n == 2) begin
      d[7:0]   = para_slot[0][7:0];
      d[8]     = c.lock;
      d[9 + k] = 1'b1;
      acks     = {c.a1req, c.a0req, c.ureq};
    end else if (n == 3) begin
      d[0]    = c.ureq;
      d[1]    = c.a0req;
      d[2]    = c.a1req;
      d[3]    = c.line_ready;
      d[4]    = c.vsyn;
      d[17:5] = para_slot[k];
    end else if (n == 4) begin
      if (c.ureq) d = {32'd0, c.ud};
    end else if (n == 5) begin
      if (c.a0req) d = c.a0d;
    end else if (n == 6) begin
      if (c.a1req) d = c.a1d;
    end else if (n >= 9 && n <= 488) begin
      if (c.line_ready) d = base + 64'(n - 9);
    end
    return {acks, fs, head, d};
  endfunction

  function automatic frame_cfg_t blank_cfg();
    frame_cfg_t c;
    c.lock = 1'b0; c.vsyn = 1'b0; c.line_ready = 1'b0;
    c.ureq = 1'b0; c.a0req = 1'b0; c.a1req = 1'b0; c.late_ureq = 1'b0;
    c.ud = 32'd0; c.late_ud = 32'd0; c.a0d = 64'd0; c.a1d = 64'd0;
    c.drop_en_at = -1; c.rst_at = -1;
    return c;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  o_pcs_data, 64'd0);
    check({tag, "_head"},  64'(o_pcs_head), 64'd0);
    check({tag, "_valid"}, 64'(o_pcs_valid), 64'd0);
    check({tag, "_fs"},    64'(o_frame_start), 64'd0);
    check({tag, "_acks"},  64'({o_audio1_ack, o_audio0_ack, o_uart_ack}), 64'd0);
    check({tag, "_rd_en"}, 64'(o_video_rd_en), 64'd0);
    check({tag, "_state"}, 64'(o_dbg_state), 64'd0);
  endtask

  // ---------------- line FIFO model (1-cycle read latency) ----------------
  initial begin
    logic rd;
    i_video_data = 64'd0;
    forever begin
      @(negedge i_pcs_clk);
      rd = o_video_rd_en;
      @(posedge i_pcs_clk);
      #1;
      if (rd) begin
        i_video_data = rd_total;
        rd_total     = rd_total + 64'd1;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge one cycle before the DUT counter reaches word 0.
  task automatic run_frame(input frame_cfg_t c);
    logic [63:0] base;
    int          k_use;
    k_use = exp_k;
    base  = 64'd0;
    for (int n = 0; n < 528; n++) begin
      @(posedge i_pcs_clk);
      @(negedge i_pcs_clk);
      if (n == 0) begin
        i_video_lock = c.lock;
        i_video_vsyn = c.vsyn;
        i_line_ready = c.line_ready;
        if (c.ureq)  begin i_uart_req = 1'b1;   i_uart_data = c.ud;    end
        if (c.a0req) begin i_audio0_req = 1'b1; i_audio0_data = c.a0d; end
        if (c.a1req) begin i_audio1_req = 1'b1; i_audio1_data = c.a1d; end
        base = rd_total;
      end
      if (n == 3) begin
        i_uart_req   = 1'b0;
        i_audio0_req = 1'b0;
        i_audio1_req = 1'b0;
      end
      if (c.late_ureq && n == 100) begin
        i_uart_req  = 1'b1;
        i_uart_data = c.late_ud;
      end
      if (n == c.drop_en_at) i_tx_en = 1'b0;
      if (n == c.rst_at) begin
        #1;
        i_rst_n = 1'b0;
        #1;
        check_outputs_zero("midframe_rst");
        check("midframe_rst_queue", 64'(exp_q.size()), 64'd0);
        exp_k = 0;
        return;
      end
      if (n < 512) exp_q.push_back({10'(n), exp_word(n, c, k_use, base)});
    end
    check($sformatf("rd_en_cycles_k%0d", k_use), rd_total - base,
          c.line_ready ? 64'd480 : 64'd0);
    exp_k = (exp_k == 8) ? 0 : exp_k + 1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [78:0] e;
    logic [68:0] got;
    forever begin
      @(negedge i_pcs_clk);
      if (i_rst_n && o_pcs_valid) begin
        got = {o_audio1_ack, o_audio0_ack, o_uart_ack, o_frame_start, o_pcs_head, o_pcs_data};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got head=%b data=%h, expected no valid word",
                   o_pcs_head, o_pcs_data);
        end else begin
          e = exp_q.pop_front();
          if (got !== e[68:0]) begin
            n_fail++;
            $display("FAIL word_%0d: got acks=%b fs=%b head=%b data=%h expected acks=%b fs=%b head=%b data=%h",
                     e[78:69], got[68:66], got[65], got[64], got[63:0],
                     e[68:66], e[65], e[64], e[63:0]);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    frame_cfg_t c;
    para_slot[0] = 13'h05A;
    para_slot[1] = 13'd1920;
    para_slot[2] = 13'd1125;
    for (int i = 3; i < 9; i++) para_slot[i] = 13'(i * 100 + 7);
    for (int i = 0; i < 9; i++) i_para[13*i +: 13] = para_slot[i];
    i_rst_n = 1'b0; i_tx_en = 1'b0;
    i_video_lock = 1'b0; i_video_vsyn = 1'b0; i_line_ready = 1'b0;
    i_uart_req = 1'b0; i_audio0_req = 1'b0; i_audio1_req = 1'b0;
    i_uart_data = 32'd0; i_audio0_data = 64'd0; i_audio1_data = 64'd0;

    repeat (3) @(negedge i_pcs_clk);
    check_outputs_zero("reset");
    i_rst_n = 1'b1;
    @(negedge i_pcs_clk);
    check_outputs_zero("idle");

    i_tx_en = 1'b1;
    // Frame 0: plain frame, no requests, no video.
    c = blank_cfg(); c.lock = 1'b1;
    run_frame(c);
    // Frame 1: video line ready.
    c = blank_cfg(); c.lock = 1'b1; c.line_ready = 1'b1;
    run_frame(c);
    // Frame 2 (slot 2 = 1125): uart + audio0, video, late uart request.
    c = blank_cfg(); c.lock = 1'b1; c.vsyn = 1'b1; c.line_ready = 1'b1;
    c.ureq = 1'b1; c.ud = 32'hDEAD_BEEF;
    c.a0req = 1'b1; c.a0d = 64'h0123_4567_89AB_CDEF;
    c.late_ureq = 1'b1; c.late_ud = 32'h1234_5678;
    run_frame(c);
    // Frame 3: late uart request honoured here, plus audio1.
    c = blank_cfg(); c.ureq = 1'b1; c.ud = 32'h1234_5678;
    c.a1req = 1'b1; c.a1d = 64'hCAFE_F00D_5555_AAAA;
    run_frame(c);
    // Frames 4..8: no requests; uart flag must be clear again.
    for (int f = 4; f < 9; f++) begin
      c = blank_cfg(); c.vsyn = f[0]; c.line_ready = (f == 6);
      run_frame(c);
    end
    // Frame 9: slot wraps to 0; enable drops mid-frame.
    c = blank_cfg(); c.lock = 1'b1; c.line_ready = 1'b1; c.drop_en_at = 100;
    run_frame(c);
    repeat (3) @(negedge i_pcs_clk);
    check("after_drop_valid", 64'(o_pcs_valid), 64'd0);
    check("after_drop_state", 64'(o_dbg_state), 64'd0);
    check("after_drop_rd_en", 64'(o_video_rd_en), 64'd0);
    check("after_drop_queue", 64'(exp_q.size()), 64'd0);

    // Restart on slot 1, reset at word 300.
    i_tx_en = 1'b1;
    c = blank_cfg(); c.line_ready = 1'b1; c.rst_at = 300;
    run_frame(c);
    @(negedge i_pcs_clk);
    i_rst_n = 1'b1;
    // First frame after reset: word 0 onward, slot 0.
    c = blank_cfg(); c.lock = 1'b1; c.drop_en_at = 10;
    run_frame(c);
    repeat (3) @(negedge i_pcs_clk);
    check("end_valid", 64'(o_pcs_valid), 64'd0);
    check("end_queue", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
